// File: rtl/dff_pkg.sv
// ---------------------------------------------------------------------------
// dff_pkg
// Shared constants and helpers for the dff_pipeline block.
//   DFF_DEF_WIDTH   : default data bits per stage
//   DFF_DEF_DEPTH   : default number of register stages
//   dff_count_width : bit width of the occupancy counter for a given depth
// ---------------------------------------------------------------------------
package dff_pkg;

    localparam int DFF_DEF_WIDTH = 8;
    localparam int DFF_DEF_DEPTH = 4;

    // The counter must represent 0..DEPTH inclusive, so it needs
    // $clog2(DEPTH+1) bits; never let it collapse to a zero-width vector.
    function automatic int dff_count_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_pipeline_if.sv
// ---------------------------------------------------------------------------
// dff_pipeline_if
// Handshake bundle between a producer/consumer and the dff_pipeline.
//   in_valid / in_ready / in_data    : producer side
//   out_valid / out_ready / out_data : consumer side
//   flush                            : synchronous clear request
//   count                            : number of occupied stages
// Modports:
//   slave  : the pipeline itself
//   master : the environment driving it
// ---------------------------------------------------------------------------
interface dff_pipeline_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_DEF_WIDTH,
    parameter int DEPTH = DFF_DEF_DEPTH
) ();

    localparam int CW = dff_count_width(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// ---------------------------------------------------------------------------
// dff_pipe_stage
// One register stage of the pipeline: WIDTH data bits plus a valid bit.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : stage takes src_valid/src_data this edge
//   flush        : clear the valid bit this edge (overrides load)
//   src_valid    : upstream valid
//   src_data     : upstream data
//   valid, data  : registered stage contents
// ---------------------------------------------------------------------------
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    // Loading an empty source produces a bubble: the valid bit drops but
    // the data register keeps its old contents, saving a data toggle.
    // flush only touches the valid bit; data is left as-is.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = src_valid;
            if (src_valid) begin
                data_d = src_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/dff_pipeline.sv
// ---------------------------------------------------------------------------
// dff_pipeline
// DEPTH-stage registered delay line with valid/ready flow control, bubble
// collapsing, synchronous flush and a registered occupancy count.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : dff_pipeline_if.slave (in_*, out_*, flush, count)
// Stage 0 faces the producer, stage DEPTH-1 drives out_valid/out_data.
// ---------------------------------------------------------------------------
module dff_pipeline
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEF_WIDTH,
    parameter int               DEPTH     = DFF_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    dff_pipeline_if.slave bus
);

    localparam int CW = dff_count_width(DEPTH);

    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data   [DEPTH];
    logic [DEPTH-1:0] ready;

    logic          in_hs;
    logic          out_hs;
    logic [CW-1:0] count_d, count_q;

    // Each stage is fed by its upstream neighbour; stage 0 by the producer.
    always_comb begin
        src_valid[0] = bus.in_valid;
        src_data[0]  = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = stage_valid[k-1];
            src_data[k]  = stage_data[k-1];
        end
    end

    // Ready ripples from the consumer back to the producer: a stage can
    // load if it is empty or if its contents move on this edge. Any empty
    // stage therefore makes every stage upstream of it ready, which is what
    // lets bubbles collapse while the output is stalled.
    always_comb begin
        logic r;
        r     = bus.out_ready;
        ready = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r        = !stage_valid[k] || r;
            ready[k] = r;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (ready[k]),
            .flush     (bus.flush),
            .src_valid (src_valid[k]),
            .src_data  (src_data[k]),
            .valid     (stage_valid[k]),
            .data      (stage_data[k])
        );
    end

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;

    // An output handshake during flush still counts as consumed, but the
    // flush empties everything, so the counter simply returns to zero.
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_hs) - CW'(out_hs);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = ready[0] && !bus.flush;
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out_data  = stage_data[DEPTH-1];
    assign bus.count     = count_q;

endmodule

// File: doc/dff_pipeline.md
Name: dff_pipeline

Overview:
Parametrised successor to the single-bit D flip-flop: a chain of DEPTH registered stages, each WIDTH bits wide, with a per-stage valid bit and valid/ready flow control. Bubbles collapse: an empty stage always accepts data, even when the output is stalled. Used as a retiming/delay element between producer and consumer blocks that need backpressure, synchronous flush and occupancy visibility.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of register stages and maximum entries held (>=1)
RESET_VAL, 0, value loaded into every stage data register on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer has data on in_data
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  write data
out_valid  output  1  last stage holds valid data
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  data of the last stage
flush  input  1  synchronous clear of all entries
count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset (reset_n=0, any time, including mid-transfer): all stage valid bits go to 0 and all stage data go to RESET_VAL immediately. Outputs read out_valid=0, out_data=RESET_VAL, count=0, and in_ready=1 once flush=0. Reset release is sampled on the next rising edge.
- Stage index 0 is the input side and DEPTH-1 is the output side. Define ready[DEPTH]=out_ready and ready[k] = !valid[k] || ready[k+1]. Then in_ready = ready[0] && !flush.
- Stage k loads on a clock edge when ready[k]=1. The source is in_data/in_valid for k=0, and stage k-1 data/valid otherwise. If the source is not valid, valid[k] becomes 0 and the data register holds its old value.
- The ready chain is combinational from out_ready to in_ready, with no skid. This is accepted for DEPTH<=8. Larger DEPTH is outside the validated range.
- Transfers: input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
- out_data and out_valid come directly from the last-stage registers, with no combinational path from in_data.
- Latency: DEPTH cycles from input handshake to out_valid when the pipeline is empty and out_ready=1. Throughput is 1 word/cycle sustained.
- Capacity: with out_ready=0, words advance until they stack at the output end. After DEPTH accepted words, in_ready=0.
- Ordering: strictly FIFO. No word is dropped or duplicated except by flush or reset.
- count: registered. Next count = count + input handshake − output handshake, computed in the same edge.
  - Simultaneous in and out handshakes leave count unchanged.
  - count never exceeds DEPTH and never goes below 0.
- flush=1 at an edge:
  - All valid bits are 0 after the edge and count=0.
  - During the flush cycle, in_ready=0, so no input is accepted.
  - out_valid still shows the pre-flush value during that cycle. Any output handshake in that cycle is honoured, and then the pipeline is cleared.
  - Data registers are not cleared.
- flush has priority over all stage loads. reset_n has priority over flush.
- out_data is undefined (don't-care) for checking whenever out_valid=0.

Decomposition:
- Package dff_pkg:
  - DFF_DEF_WIDTH=8 and DFF_DEF_DEPTH=4 default constants.
  - A function computing the count width, $clog2(DEPTH+1) with a minimum of 1.
- Sub-module dff_pipe_stage: one WIDTH-bit register with valid bit, async active-low reset to RESET_VAL, load enable and synchronous flush.
- dff_pipeline instantiates DEPTH copies of dff_pipe_stage in a generate loop and adds the ready chain and the count register.

Test Plan:
1. Reset mid-stream (WIDTH=8, DEPTH=4): load 3 words, pull reset_n low between edges -> out_valid=0, count=0 and out_data=RESET_VAL immediately, before the next edge.
2. Streaming, out_ready=1: push 0x11, 0x22, 0x33 back-to-back -> 0x11 appears with out_valid=1 exactly 4 cycles after its handshake, followed by 0x22 and 0x33 on consecutive cycles. count peaks at 3.
3. Backpressure and bubble collapse: out_ready=0, push 0xA1 then a 2-cycle bubble then 0xA2, 0xA3, 0xA4 -> all 4 accepted, count=4, in_ready=0 on the 5th attempt. With out_ready=1, the words drain in order 0xA1..0xA4.
4. Simultaneous in/out at full: count=4, in_valid=1 and out_ready=1 -> in_ready=1, count stays 4, and the new word exits 4 words later.
5. Flush with handshake: count=3, out_ready=1, in_valid=1, flush=1 for one cycle -> that cycle's output word is consumed and the input is not accepted. Next cycle out_valid=0, count=0, in_ready=1.
6. Parameter sweep: DEPTH=1/WIDTH=1 and DEPTH=8/WIDTH=32 -> scoreboard checks order, latency=DEPTH, and full condition at count=DEPTH under random in_valid/out_ready.
